// File: rtl/mem_bridge_pkg.sv
// Shared types and helpers for the kernel memory-port bridge.
// FSM state encoding and the external byte-address computation.
package mem_bridge_pkg;

    typedef enum logic [2:0] {
        RUN,
        ISSUE,
        WAIT_RD,
        WAIT_WR,
        RESUME,
        DONE
    } state_t;

    localparam int EXT_AW = 64;

    // Word address is already widened to 64 bits; the sum wraps mod 2^64.
    function automatic logic [EXT_AW-1:0] byte_addr(
        input logic [EXT_AW-1:0] base,
        input logic [EXT_AW-1:0] word,
        input int unsigned       shift
    );
        return base + (word << shift);
    endfunction

    // Index width for an n-entry port set, never narrower than 1 bit.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prio_pick.sv
// Lowest-set-bit encoder used to choose the next pending port.
// Port 0 has the highest priority.
module prio_pick
    import mem_bridge_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan from the top so the lowest set bit is written last.
    always_comb begin
        idx   = '0;
        valid = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mem_port_bridge.sv
// Bridges NUM_PORTS kernel scratchpad ports onto one external rd/wr handshake,
// freezing the kernel via kernel_ce. Optional counters: MEM_PORT_BRIDGE_STATS_EN.
module mem_port_bridge
    import mem_bridge_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WID   = 12,
    parameter int DATA_WID   = 32,
    parameter int BYTE_SHIFT = 2
) (
    input  logic                          mod_clk,
    input  logic                          reset,
    input  logic [63:0]                   read_base,
    input  logic [63:0]                   write_base,
    input  logic [63:0]                   xfer_size,
    input  logic [NUM_PORTS*ADDR_WID-1:0] k_addr,
    input  logic [NUM_PORTS-1:0]          k_ce,
    input  logic [NUM_PORTS-1:0]          k_we,
    input  logic [NUM_PORTS*DATA_WID-1:0] k_d,
    output logic [NUM_PORTS*DATA_WID-1:0] k_q,
    output logic                          kernel_ce,
    output logic                          ap_start,
    input  logic                          ap_done,
    input  logic [31:0]                   ap_return,
    output logic                          rd_en,
    output logic [63:0]                   rd_addr,
    output logic [63:0]                   rd_size,
    input  logic                          rd_ready,
    input  logic [DATA_WID-1:0]           rd_data,
    output logic                          wr_en,
    output logic [63:0]                   wr_addr,
    output logic [63:0]                   wr_size,
    output logic [DATA_WID-1:0]           wr_data,
    input  logic                          wr_ready,
`ifdef MEM_PORT_BRIDGE_STATS_EN
    output logic [31:0]                   stat_reads,
    output logic [31:0]                   stat_writes,
    output logic [31:0]                   stat_stall,
`endif
    output logic                          done,
    output logic [31:0]                   returnvalue
);

    localparam int IDX_W = idx_bits(NUM_PORTS);

    state_t               state;
    logic [NUM_PORTS-1:0] pend;
    logic [NUM_PORTS-1:0] pend_we;
    logic [IDX_W-1:0]     cur_idx;
    logic [IDX_W-1:0]     sel_idx;
    logic                 sel_vld;
    logic [NUM_PORTS-1:0] cur_oh;
    logic                 more_left;
    logic                 done_pend;
    logic [31:0]          ret_lat;
    logic                 capture;
    logic                 rd_acc;
    logic                 wr_acc;

    logic [ADDR_WID-1:0] lat_addr [NUM_PORTS];
    logic [DATA_WID-1:0] lat_d    [NUM_PORTS];
    logic [DATA_WID-1:0] q_r      [NUM_PORTS];

    prio_pick #(
        .N     (NUM_PORTS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (pend),
        .idx   (sel_idx),
        .valid (sel_vld)
    );

    assign cur_oh    = NUM_PORTS'(1) << cur_idx;
    assign more_left = |(pend & ~cur_oh);
    assign capture   = (state == RUN) && (|k_ce);
    assign rd_acc    = (state == WAIT_RD) && rd_ready;
    assign wr_acc    = (state == WAIT_WR) && wr_ready;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_q
        assign k_q[p*DATA_WID +: DATA_WID] = q_r[p];
    end

    // Main control FSM; all handshake and kernel-control outputs registered.
    always_ff @(posedge mod_clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            pend        <= '0;
            pend_we     <= '0;
            cur_idx     <= '0;
            done_pend   <= 1'b0;
            ret_lat     <= '0;
            kernel_ce   <= 1'b1;
            ap_start    <= 1'b1;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            rd_size     <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_size     <= '0;
            wr_data     <= '0;
            done        <= 1'b0;
            returnvalue <= '0;
        end else begin
            rd_en <= 1'b0;
            wr_en <= 1'b0;
            unique case (state)
                RUN: begin
                    if (|k_ce) begin
                        pend      <= k_ce;
                        pend_we   <= k_we & k_ce;
                        done_pend <= ap_done;
                        ret_lat   <= ap_return;
                        kernel_ce <= 1'b0;
                        state     <= ISSUE;
                    end else if (ap_done) begin
                        done        <= 1'b1;
                        returnvalue <= ap_return;
                        kernel_ce   <= 1'b0;
                        ap_start    <= 1'b0;
                        state       <= DONE;
                    end
                end
                ISSUE: begin
                    if (!sel_vld) begin
                        state <= RESUME;
                    end else if (pend_we[sel_idx]) begin
                        cur_idx <= sel_idx;
                        wr_en   <= 1'b1;
                        wr_addr <= byte_addr(write_base,
                                             64'(lat_addr[sel_idx]),
                                             BYTE_SHIFT);
                        wr_data <= lat_d[sel_idx];
                        wr_size <= xfer_size;
                        state   <= WAIT_WR;
                    end else begin
                        cur_idx <= sel_idx;
                        rd_en   <= 1'b1;
                        rd_addr <= byte_addr(read_base,
                                             64'(lat_addr[sel_idx]),
                                             BYTE_SHIFT);
                        rd_size <= xfer_size;
                        state   <= WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    if (rd_ready) begin
                        pend  <= pend & ~cur_oh;
                        state <= more_left ? ISSUE : RESUME;
                    end
                end
                WAIT_WR: begin
                    if (wr_ready) begin
                        pend  <= pend & ~cur_oh;
                        state <= more_left ? ISSUE : RESUME;
                    end
                end
                RESUME: begin
                    // A done raised alongside accesses finishes after them.
                    if (done_pend) begin
                        done        <= 1'b1;
                        returnvalue <= ret_lat;
                        ap_start    <= 1'b0;
                        state       <= DONE;
                    end else begin
                        kernel_ce <= 1'b1;
                        state     <= RUN;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    // Capture request addresses/data and return read data to the port.
    always_ff @(posedge mod_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                lat_addr[i] <= '0;
                lat_d[i]    <= '0;
                q_r[i]      <= '0;
            end
        end else begin
            if (capture) begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (k_ce[i]) begin
                        lat_addr[i] <= k_addr[i*ADDR_WID +: ADDR_WID];
                        lat_d[i]    <= k_d[i*DATA_WID +: DATA_WID];
                    end
                end
            end
            if (rd_acc) begin
                q_r[cur_idx] <= rd_data;
            end
        end
    end

`ifdef MEM_PORT_BRIDGE_STATS_EN
    // Saturating access and stall counters.
    always_ff @(posedge mod_clk or posedge reset) begin
        if (reset) begin
            stat_reads  <= '0;
            stat_writes <= '0;
            stat_stall  <= '0;
        end else begin
            if (rd_acc && stat_reads != '1) begin
                stat_reads <= stat_reads + 32'd1;
            end
            if (wr_acc && stat_writes != '1) begin
                stat_writes <= stat_writes + 32'd1;
            end
            if (!kernel_ce && state != DONE && stat_stall != '1) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`else
    logic unused_acc;
    assign unused_acc = wr_acc;
`endif

endmodule

// File: tb/tb_mem_port_bridge.sv
// Directed self-checking bench for mem_port_bridge with four kernel ports.
// A small byte-addressed memory model answers the rd/wr handshake.
module tb_mem_port_bridge;

    localparam int NP = 4;
    localparam int AW = 12;
    localparam int DW = 32;

    logic             mod_clk;
    logic             reset;
    logic [63:0]      read_base;
    logic [63:0]      write_base;
    logic [63:0]      xfer_size;
    logic [NP*AW-1:0] k_addr;
    logic [NP-1:0]    k_ce;
    logic [NP-1:0]    k_we;
    logic [NP*DW-1:0] k_d;
    logic [NP*DW-1:0] k_q;
    logic             kernel_ce;
    logic             ap_start;
    logic             ap_done;
    logic [31:0]      ap_return;
    logic             rd_en;
    logic [63:0]      rd_addr;
    logic [63:0]      rd_size;
    logic             rd_ready;
    logic [DW-1:0]    rd_data;
    logic             wr_en;
    logic [63:0]      wr_addr;
    logic [63:0]      wr_size;
    logic [DW-1:0]    wr_data;
    logic             wr_ready;
    logic             done;
    logic [31:0]      returnvalue;
`ifdef MEM_PORT_BRIDGE_STATS_EN
    logic [31:0]      stat_reads;
    logic [31:0]      stat_writes;
    logic [31:0]      stat_stall;
`endif

    int n_cmp;
    int n_fail;

    logic [31:0] mem [logic [63:0]];
    bit          ev_rd [$];
    logic [63:0] ev_addr [$];

    mem_port_bridge #(
        .NUM_PORTS  (NP),
        .ADDR_WID   (AW),
        .DATA_WID   (DW),
        .BYTE_SHIFT (2)
    ) dut (
        .mod_clk     (mod_clk),
        .reset       (reset),
        .read_base   (read_base),
        .write_base  (write_base),
        .xfer_size   (xfer_size),
        .k_addr      (k_addr),
        .k_ce        (k_ce),
        .k_we        (k_we),
        .k_d         (k_d),
        .k_q         (k_q),
        .kernel_ce   (kernel_ce),
        .ap_start    (ap_start),
        .ap_done     (ap_done),
        .ap_return   (ap_return),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_size     (rd_size),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_size     (wr_size),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
`ifdef MEM_PORT_BRIDGE_STATS_EN
        .stat_reads  (stat_reads),
        .stat_writes (stat_writes),
        .stat_stall  (stat_stall),
`endif
        .done        (done),
        .returnvalue (returnvalue)
    );

    initial mod_clk = 1'b0;
    always #5 mod_clk = ~mod_clk;

    function automatic logic [31:0] qp(input int p);
        return k_q[p*DW +: DW];
    endfunction

    // Present one kernel cycle of requests, then step past the capture edge.
    task automatic kick(input logic [NP-1:0] ce, input logic [NP-1:0] we,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                        input logic [DW-1:0] d0);
        k_ce = ce;
        k_we = we;
        k_addr = {a3, a2, a1, a0};
        k_d = {32'h0, 32'h0, 32'h0, d0};
        @(posedge mod_clk);
        #1;
        k_ce = '0;
        k_we = '0;
    endtask

    // Answer the handshake with 'lat' extra cycles; count stalled cycles.
    task automatic serve(input int lat, output int low);
        int cnt;
        bit kind_rd;
        logic [63:0] a;
        int guard;
        cnt = -1;
        low = 0;
        guard = 0;
        kind_rd = 1'b0;
        a = '0;
        ev_rd.delete();
        ev_addr.delete();
        while (1) begin
            @(negedge mod_clk);
            rd_ready = 1'b0;
            wr_ready = 1'b0;
            if (kernel_ce) break;
            low++;
            if (rd_en) begin
                ev_rd.push_back(1'b1);
                ev_addr.push_back(rd_addr);
                kind_rd = 1'b1;
                a = rd_addr;
                cnt = lat;
            end
            if (wr_en) begin
                ev_rd.push_back(1'b0);
                ev_addr.push_back(wr_addr);
                mem[wr_addr] = wr_data;
                kind_rd = 1'b0;
                cnt = lat;
            end
            if (cnt == 0) begin
                if (kind_rd) begin
                    rd_ready = 1'b1;
                    rd_data = mem.exists(a) ? mem[a] : 32'hBAD0BAD0;
                end else begin
                    wr_ready = 1'b1;
                end
                cnt = -1;
            end else if (cnt > 0) begin
                cnt--;
            end
            guard++;
            if (guard > 200) begin
                n_cmp++;
                n_fail++;
                $display("FAIL serve_timeout: kernel_ce still 0");
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        n_cmp++;
        if (kernel_ce !== 1'b1 || ap_start !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ce: ce=%b start=%b want 1 1",
                     kernel_ce, ap_start);
        end
        n_cmp++;
        if (rd_en !== 1'b0 || wr_en !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: rd_en=%b wr_en=%b done=%b want 0",
                     rd_en, wr_en, done);
        end
        n_cmp++;
        if (returnvalue !== 32'h0 || k_q !== '0 || rd_addr !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_data: ret=%h kq=%h rd_addr=%h want 0",
                     returnvalue, k_q, rd_addr);
        end
        @(negedge mod_clk);
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        int low;
        read_base = 64'h1000;
        mem[64'h1014] = 32'hDEAD;
        kick(4'b0001, 4'b0000, 12'd5, 12'd0, 12'd0, 12'd0, 32'h0);
        serve(3, low);
        n_cmp++;
        if (ev_addr.size() != 1 || !ev_rd[0]
            || ev_addr[0] !== 64'h1014) begin
            n_fail++;
            $display("FAIL single_rd_addr: n=%0d first=%h want 1 rd 1014",
                     ev_addr.size(),
                     ev_addr.size() > 0 ? ev_addr[0] : 64'h0);
        end
        n_cmp++;
        if (low != 6) begin
            n_fail++;
            $display("FAIL single_stall: got %0d want 6", low);
        end
        n_cmp++;
        if (qp(0) !== 32'hDEAD || qp(1) !== 32'h0) begin
            n_fail++;
            $display("FAIL single_q: q0=%h q1=%h want dead 0",
                     qp(0), qp(1));
        end
        n_cmp++;
        if (rd_size !== 64'h4) begin
            n_fail++;
            $display("FAIL rd_size: got %h want 4", rd_size);
        end
    endtask

    task automatic test_write_then_read();
        int low;
        read_base = 64'h2000;
        write_base = 64'h2000;
        mem[64'h200C] = 32'h1111;
        kick(4'b0011, 4'b0001, 12'd3, 12'd3, 12'd0, 12'd0, 32'd7);
        serve(0, low);
        n_cmp++;
        if (ev_addr.size() != 2) begin
            n_fail++;
            $display("FAIL wr_rd_count: got %0d pulses want 2",
                     ev_addr.size());
        end else begin
            n_cmp++;
            if (ev_rd[0] || ev_addr[0] !== 64'h200C
                || !ev_rd[1] || ev_addr[1] !== 64'h200C) begin
                n_fail++;
                $display("FAIL wr_rd_order: %b@%h %b@%h want 0@200c 1@200c",
                         ev_rd[0], ev_addr[0], ev_rd[1], ev_addr[1]);
            end
        end
        n_cmp++;
        if (low != 5) begin
            n_fail++;
            $display("FAIL wr_rd_stall: got %0d want 5", low);
        end
        n_cmp++;
        if (qp(1) !== 32'd7 || qp(0) !== 32'hDEAD) begin
            n_fail++;
            $display("FAIL wr_rd_q: q1=%h q0=%h want 7 dead",
                     qp(1), qp(0));
        end
        n_cmp++;
        if (wr_size !== 64'h4) begin
            n_fail++;
            $display("FAIL wr_size: got %h want 4", wr_size);
        end
    endtask

    task automatic test_four_reads();
        int low;
        logic [63:0] exp_a [4];
        logic [31:0] exp_q [4];
        exp_a = '{64'h3004, 64'h3008, 64'h300C, 64'h3010};
        exp_q = '{32'hA1, 32'hB2, 32'hC3, 32'hD4};
        read_base = 64'h3000;
        for (int i = 0; i < 4; i++) mem[exp_a[i]] = exp_q[i];
        kick(4'b1111, 4'b0000, 12'd1, 12'd2, 12'd3, 12'd4, 32'h0);
        serve(0, low);
        n_cmp++;
        if (ev_addr.size() != 4) begin
            n_fail++;
            $display("FAIL four_count: got %0d want 4", ev_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (!ev_rd[i] || ev_addr[i] !== exp_a[i]) begin
                    n_fail++;
                    $display("FAIL four_addr%0d: got %h want %h",
                             i, ev_addr[i], exp_a[i]);
                end
            end
        end
        n_cmp++;
        if (low != 9) begin
            n_fail++;
            $display("FAIL four_stall: got %0d want 9", low);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (qp(i) !== exp_q[i]) begin
                n_fail++;
                $display("FAIL four_q%0d: got %h want %h",
                         i, qp(i), exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        int guard;
        read_base = 64'h1000;
        kick(4'b0001, 4'b0000, 12'd9, 12'd0, 12'd0, 12'd0, 32'h0);
        guard = 0;
        while (1) begin
            @(negedge mod_clk);
            if (rd_en || guard > 10) break;
            guard++;
        end
        n_cmp++;
        if (rd_en !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_wait_rd_en: got %b want 1", rd_en);
        end
        #1;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (rd_en !== 1'b0 || kernel_ce !== 1'b1 || ap_start !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: rd_en=%b ce=%b start=%b want 0 1 1",
                     rd_en, kernel_ce, ap_start);
        end
        @(negedge mod_clk);
        reset = 1'b0;
        rd_ready = 1'b1;
        rd_data = 32'h5555;
        @(negedge mod_clk);
        @(negedge mod_clk);
        rd_ready = 1'b0;
        n_cmp++;
        if (qp(0) !== 32'h0 || kernel_ce !== 1'b1 || rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: q0=%h ce=%b rd_en=%b want 0 1 0",
                     qp(0), kernel_ce, rd_en);
        end
    endtask

    task automatic test_stats();
        int low;
        read_base = 64'h4000;
        write_base = 64'h4000;
        mem[64'h4018] = 32'h66;
        kick(4'b1111, 4'b0001, 12'd5, 12'd6, 12'd7, 12'd8, 32'h11);
        serve(0, low);
        n_cmp++;
        if (low != 9 || qp(1) !== 32'h66) begin
            n_fail++;
            $display("FAIL mix_cycle: stall=%0d q1=%h want 9 66",
                     low, qp(1));
        end
        kick(4'b0001, 4'b0001, 12'd5, 12'd0, 12'd0, 12'd0, 32'h22);
        serve(0, low);
        n_cmp++;
        if (low != 3 || mem[64'h4014] !== 32'h22) begin
            n_fail++;
            $display("FAIL single_wr: stall=%0d mem=%h want 3 22",
                     low, mem[64'h4014]);
        end
`ifdef MEM_PORT_BRIDGE_STATS_EN
        n_cmp++;
        if (stat_reads !== 32'd3 || stat_writes !== 32'd2) begin
            n_fail++;
            $display("FAIL stats_rw: reads=%0d writes=%0d want 3 2",
                     stat_reads, stat_writes);
        end
        n_cmp++;
        if (stat_stall !== 32'd12) begin
            n_fail++;
            $display("FAIL stats_stall: got %0d want 12", stat_stall);
        end
`endif
    endtask

    task automatic test_done();
        ap_done = 1'b1;
        ap_return = 32'd42;
        @(posedge mod_clk);
        #1;
        ap_done = 1'b0;
        ap_return = 32'd0;
        @(negedge mod_clk);
        n_cmp++;
        if (done !== 1'b1 || returnvalue !== 32'd42) begin
            n_fail++;
            $display("FAIL done_ret: done=%b ret=%0d want 1 42",
                     done, returnvalue);
        end
        n_cmp++;
        if (ap_start !== 1'b0 || kernel_ce !== 1'b0) begin
            n_fail++;
            $display("FAIL done_ctl: start=%b ce=%b want 0 0",
                     ap_start, kernel_ce);
        end
        rd_ready = 1'b1;
        rd_data = 32'hFFFF;
        k_ce = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            @(negedge mod_clk);
            n_cmp++;
            if (rd_en !== 1'b0 || wr_en !== 1'b0) begin
                n_fail++;
                $display("FAIL done_idle%0d: rd_en=%b wr_en=%b want 0 0",
                         i, rd_en, wr_en);
            end
        end
        rd_ready = 1'b0;
        k_ce = '0;
        n_cmp++;
        if (qp(1) !== 32'h66 || done !== 1'b1 || kernel_ce !== 1'b0) begin
            n_fail++;
            $display("FAIL done_hold: q1=%h done=%b ce=%b want 66 1 0",
                     qp(1), done, kernel_ce);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        read_base = '0;
        write_base = '0;
        xfer_size = 64'h4;
        k_addr = '0;
        k_ce = '0;
        k_we = '0;
        k_d = '0;
        ap_done = 1'b0;
        ap_return = '0;
        rd_ready = 1'b0;
        rd_data = '0;
        wr_ready = 1'b0;
        test_reset();
        test_single_read();
        test_write_then_read();
        test_four_reads();
        test_reset_mid_wait();
        test_stats();
        test_done();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_bridge.md
Name: mem_port_bridge

Overview:
- Parametrised bridge between an HLS kernel with NUM_PORTS scratchpad ports (address/ce/we/d/q) and a single external-memory read/write handshake.
- Captures all port requests issued in one kernel cycle and freezes the kernel via a clock enable instead of a divided clock.
- Services the captured requests serially in fixed priority order, then releases the kernel with read data presented on the per-port q outputs.
- Sits between kernel_<app> and the host memory shim; replaces per-kernel hand-written two-port wrappers.

Parameters:
- NUM_PORTS, 2, number of kernel memory ports (1..8).
- ADDR_WID, 12, kernel word-address width.
- DATA_WID, 32, data word width.
- BYTE_SHIFT, 2, log2 bytes per word; external byte address = base + (word_addr << BYTE_SHIFT).

Ports:
- mod_clk in 1: block and kernel clock.
- reset in 1: asynchronous, active-high.
- read_base in 64: external byte base for reads.
- write_base in 64: external byte base for writes.
- xfer_size in 64: value forwarded on rd_size/wr_size.
- k_addr in NUM_PORTS*ADDR_WID: port addresses, port p at slice [p*ADDR_WID +: ADDR_WID].
- k_ce in NUM_PORTS: port chip enables.
- k_we in NUM_PORTS: port write enables.
- k_d in NUM_PORTS*DATA_WID: port write data.
- k_q out NUM_PORTS*DATA_WID: port read data.
- kernel_ce out 1: kernel clock enable; kernel advances only when high.
- ap_start out 1: kernel start.
- ap_done in 1: kernel done.
- ap_return in 32: kernel return value.
- rd_en out 1: one-cycle read request pulse.
- rd_addr out 64: read byte address.
- rd_size out 64: read size.
- rd_ready in 1: read data valid.
- rd_data in DATA_WID: read data.
- wr_en out 1: one-cycle write request pulse.
- wr_addr out 64: write byte address.
- wr_size out 64: write size.
- wr_data out DATA_WID: write data.
- wr_ready in 1: write accepted.
- done out 1: kernel finished, sticky.
- returnvalue out 32: latched ap_return.

Behaviour:
- Reset values: all outputs 0 except ap_start=1 and kernel_ce=1; pending mask 0; state RUN.
- RUN:
  - If k_ce has any bit set, latch into pending: ce mask, we mask, addresses, write data. kernel_ce<=0 and go to ISSUE in the same edge.
  - Else if ap_done, go to DONE: done<=1, returnvalue<=ap_return, kernel_ce<=0, ap_start<=0.
  - If k_ce and ap_done occur in the same cycle, the accesses are serviced first; DONE is entered from RESUME.
- ISSUE:
  - Select the lowest-index set pending bit p.
  - Write: wr_en=1 for exactly one cycle, wr_addr=write_base+(addr_p<<BYTE_SHIFT), wr_data=d_p, wr_size=xfer_size; go to WAIT_WR.
  - Read: rd_en=1 for exactly one cycle, rd_addr=read_base+(addr_p<<BYTE_SHIFT), rd_size=xfer_size; go to WAIT_RD.
- WAIT_RD:
  - On rd_ready=1: q_p<=rd_data and clear pending bit p.
  - Then go to ISSUE if bits remain, else RESUME.
  - rd_ready seen in the same cycle as rd_en is accepted.
- WAIT_WR: same as WAIT_RD using wr_ready, with no q update.
- RESUME: kernel_ce<=1 and go to RUN. The kernel therefore sees q valid on its first enabled edge after the request, which is 1-cycle BRAM latency from its view.
- k_q per port holds its last read value. Writes and non-enabled ports leave it unchanged.
- Two ports addressing the same word in one cycle are serialised in priority order; a read following a write returns the new data.
- ADDR_WID shift is widened to 64 bits before the add; the sum wraps modulo 2^64.
- DONE: hold kernel_ce=0, done=1; ignore k_ce and ready inputs.
- Asynchronous reset at any point, including mid-WAIT: drops rd_en/wr_en immediately and returns to the reset state. No completion is reported for the lost access.
- Minimum stall per kernel cycle with m accesses: 2m+1 mod_clk cycles.

Optional Feature:
- MEM_PORT_BRIDGE_STATS_EN defined:
  - Adds outputs stat_reads, stat_writes, stat_stall (32 bits each).
  - stat_reads/stat_writes increment on each accepted ready; stat_stall increments every cycle kernel_ce=0 outside DONE.
  - All saturate at 0xFFFFFFFF and reset to 0.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mem_bridge_pkg: state enum (RUN, ISSUE, WAIT_RD, WAIT_WR, RESUME, DONE) and the byte-address helper function.
- Sub-module prio_pick: NUM_PORTS-bit lowest-set-bit encoder giving index and valid.

Test Plan:
- Single read, port0 addr 5, read_base 0x1000, rd_ready 3 cycles later with 0xDEAD -> rd_addr=0x1014; k_q[0]=0xDEAD when kernel_ce rises; kernel_ce low for 6 cycles.
- Port0 write addr 3 data 7 and port1 read addr 3 in the same cycle -> wr to write_base+12 issued before rd to read_base+12; exactly one wr_en and one rd_en pulse.
- NUM_PORTS=4, all ports reading addrs 1..4 -> rd_addr sequence +4, +8, +12, +16; each k_q correct; kernel_ce low for 9 cycles with immediate readies.
- ap_done with ap_return 42 and no ce -> done=1 next edge, returnvalue=42, ap_start=0; later rd_ready is ignored.
- Reset asserted during WAIT_RD -> rd_en=0 and kernel_ce=1 asynchronously; no q update.
- With MEM_PORT_BRIDGE_STATS_EN, 3 reads and 2 writes -> stat_reads=3, stat_writes=2.
